aes_decrypt_param_core: RTL and testbench
=========================================

AES_DECRYPT_PARAM_CORE -- requirements
Module: aes_decrypt_param_core

Interface
REQ-001 The module SHALL have parameter KEY_BITS, default 128, giving the key length; only 128 and 256 are legal.
REQ-002 The module SHALL have localparam NR, equal to 10 when KEY_BITS=128 and 14 when KEY_BITS=256, giving the round count.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  cipher_text and last_key are valid this cycle.
REQ-006 in_ready  output  1  core can accept a new block.
REQ-007 cipher_text  input  128  ciphertext block, byte 0 in [127:120].
REQ-008 last_key  input  KEY_BITS  final expanded key words (KEY_BITS=128: round key 10; KEY_BITS=256: [255:128] round key 13, [127:0] round key 14).
REQ-009 out_valid  output  1  plain_text holds a completed result.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 plain_text  output  128  decrypted block.
REQ-012 busy  output  1  high while a block is being processed or held (state not IDLE).

Function
REQ-013 The core SHALL implement the FIPS-197 inverse cipher as an iterative datapath, one round per clock.
REQ-014 The core SHALL regenerate round keys on the fly by inverse key expansion from last_key, without a stored key table.
REQ-015 The FSM SHALL have three states: IDLE, ROUND and DONE.
REQ-016 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in DONE.
REQ-017 IDLE: on in_valid && in_ready, the core SHALL:
- load state <= cipher_text XOR round key NR;
- load the key register from last_key;
- set the round counter to NR-1;
- go to ROUND.
REQ-018 ROUND, each cycle: the core SHALL compute state <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[cnt])).
REQ-019 When cnt=0, the core SHALL skip InvMixColumns and go to DONE; otherwise it SHALL decrement cnt.
REQ-020 Latency: out_valid SHALL rise exactly NR clock edges after the accepting edge (10 or 14).
REQ-021 DONE: plain_text and out_valid SHALL hold stable until out_valid && out_ready, after which the core SHALL return to IDLE.
REQ-022 No new block SHALL be accepted in DONE, even if out_ready is high in that cycle.
REQ-023 in_valid SHALL be ignored in ROUND and DONE; cipher_text and last_key changes there SHALL NOT affect the result.
REQ-024 Inverse key step, KEY_BITS=128: rk[r-1] SHALL be derived from rk[r] using the inverse of the forward recurrence, with Rcon indexed by r.
REQ-025 Inverse key step, KEY_BITS=256: the key register SHALL hold {rk[r-1], rk[r]}; each step SHALL shift in rk[r-2].
REQ-026 For KEY_BITS=256, the SubWord(RotWord)+Rcon step and the SubWord-only step SHALL alternate per FIPS-197.
REQ-027 The round counter SHALL be ceil(log2(NR)) bits wide and SHALL never wrap below 0.
REQ-028 Back-to-back operation: a new block SHALL be accepted in IDLE one cycle after the output handshake, giving a throughput of one block per NR+2 cycles.

Reset
REQ-029 While reset_n=0, the core SHALL force state=IDLE, in_ready=0, out_valid=0, busy=0, plain_text=0, cnt=0 and key register=0.
REQ-030 in_ready SHALL go high in the first cycle after reset_n deasserts.
REQ-031 Reset asserted during ROUND or DONE SHALL abort the block immediately; no out_valid SHALL follow for that block.

Structure
REQ-032 The following SHALL live in the shared AES package:
- inverse S-box and forward S-box functions (the forward S-box is used by the key step);
- Rcon function;
- GF(2^8) multiply function;
- InvShiftRows function;
- FSM state enum typedef.
REQ-033 A sub-module aes_inv_key_step SHALL implement one inverse key-expansion step, parameterised by KEY_BITS.

Verification
REQ-034 KEY_BITS=128, cipher_text=69c4e0d86a7b0430d8cdb78070b4c55a, last_key=13111d7fe3944a17f307a78b4d2b30c5 -> out_valid 10 edges after accept, plain_text=00112233445566778899aabbccddeeff.
REQ-035 KEY_BITS=256, cipher_text=8ea2b7ca516745bfeafc49904b496089, last_key={4e5a6699a9f24fe07e572baacdf8cdea, 24fc79ccbf0979e9371ac23c6d68de36} -> out_valid 14 edges after accept, plain_text=00112233445566778899aabbccddeeff.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles after out_valid -> plain_text stable, in_ready=0 throughout; release -> IDLE next cycle.
REQ-037 Second in_valid pulse with different data during ROUND -> ignored; result is unchanged from REQ-034.
REQ-038 reset_n pulsed low at round 5 -> all outputs 0 immediately; a fresh REQ-034 run afterwards passes.
REQ-039 Two blocks back-to-back with out_ready tied to 1 -> second accepted at edge NR+2 after the first accept; both results correct.

Source files
------------

// File: rtl/aes_decrypt_param_core_pkg.sv
// aes_decrypt_param_core_pkg: GF(2^8) arithmetic, S-boxes, Rcon and inverse round helpers for the AES decrypt core
package aes_decrypt_param_core_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, DONE = 2'd2} state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = xtime(a);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl(x, 1) ^ rotl(x, 3) ^ rotl(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    c = 8'h01;
    for (int i = 2; i <= 14; i++)
      if (i <= {28'd0, r}) c = xtime(c);
    return c;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // byte n = row + 4*col lives at [127-8n -: 8]; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int n = 0; n < 16; n++) o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [31:0] m;
    m = 32'h0e0b0d09;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int k = 0; k < 4; k++)
          o[127-8*(r+4*c) -: 8] ^= gf_mul(m[31-8*((k-r+4)%4) -: 8], s[127-8*(k+4*c) -: 8]);
    return o;
  endfunction
endpackage

// File: rtl/aes_decrypt_param_core_inv_key_step.sv
// aes_inv_key_step: one backwards step of the AES key schedule; rk is the round key used with this step
module aes_inv_key_step
  import aes_decrypt_param_core_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic [KEY_BITS-1:0] key_in,
  input  logic [3:0]          r,
  output logic [KEY_BITS-1:0] key_out,
  output logic [127:0]        rk
);
  if (KEY_BITS == 256) begin : g_256
    logic [31:0] k0, k1, k2, k3, k4, k5, k6, k7, t;
    assign {k0, k1, k2, k3, k4, k5, k6, k7} = key_in;
    assign t = r[0] ? sub_word(k3) : sub_word(rot_word(k3)) ^ {rcon({1'b0, r[3:1]}), 24'h0};
    assign key_out = {k4 ^ t, k5 ^ k4, k6 ^ k5, k7 ^ k6, k0, k1, k2, k3};
    assign rk = key_in[255:128];
  end else begin : g_128
    logic [31:0] a0, a1, a2, a3, b3;
    assign {a0, a1, a2, a3} = key_in;
    assign b3 = a3 ^ a2;
    assign key_out = {a0 ^ sub_word(rot_word(b3)) ^ {rcon(r), 24'h0}, a1 ^ a0, a2 ^ a1, b3};
    assign rk = key_out;
  end
endmodule

// File: rtl/aes_decrypt_param_core.sv
// aes_decrypt_param_core: iterative AES-128/256 inverse cipher, one round per clock, on-the-fly key schedule
module aes_decrypt_param_core
  import aes_decrypt_param_core_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [127:0]        cipher_text,
  input  logic [KEY_BITS-1:0] last_key,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [127:0]        plain_text,
  output logic                busy
);
  localparam int NR = KEY_BITS == 256 ? 14 : 10;
  localparam int CW = $clog2(NR);

  state_t fsm;
  logic live;
  logic [127:0] st, rk, t;
  logic [KEY_BITS-1:0] key, key_nxt;
  logic [CW-1:0] cnt;
  logic [3:0] r;

  assign r = 4'(cnt) + 4'd1;
  assign t = inv_sub_bytes(inv_shift_rows(st)) ^ rk;
  assign in_ready = live && fsm == IDLE;
  assign out_valid = fsm == DONE;
  assign busy = fsm != IDLE;
  assign plain_text = out_valid ? st : '0;

  aes_inv_key_step #(.KEY_BITS(KEY_BITS)) u_key_step (
    .key_in (key),
    .r      (r),
    .key_out(key_nxt),
    .rk     (rk)
  );

  // accept a block, run NR rounds walking the key schedule backwards, then hold the result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm <= IDLE;
      live <= 1'b0;
      st <= '0;
      key <= '0;
      cnt <= '0;
    end else begin
      live <= 1'b1;
      if (in_valid && in_ready) begin
        st <= cipher_text ^ last_key[127:0];
        key <= last_key;
        cnt <= CW'(NR - 1);
        fsm <= ROUND;
      end else if (fsm == ROUND) begin
        st <= cnt == '0 ? t : inv_mix_columns(t);
        key <= key_nxt;
        cnt <= cnt == '0 ? cnt : cnt - 1'b1;
        fsm <= cnt == '0 ? DONE : ROUND;
      end else if (fsm == DONE && out_ready) begin
        fsm <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_aes_decrypt_param_core.sv
// tb_aes_decrypt_param_core: random and known-answer checks of both key sizes against a forward-cipher model
module tb_aes_decrypt_param_core;
  localparam logic [127:0] KAT_PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] KAT128_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] KAT128_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] KAT256_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KAT256_KEY = {128'h4e5a6699a9f24fe07e572baacdf8cdea, 128'h24fc79ccbf0979e9371ac23c6d68de36};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sel = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [127:0] cipher_text = '0;
  logic [255:0] last_key = '0;
  logic ir0, ir1, ov0, ov1, bz0, bz1;
  logic [127:0] pt0, pt1;
  logic in_ready, out_valid, busy;
  logic [127:0] plain_text;
  logic [7:0] sb [256];
  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign in_ready = sel ? ir1 : ir0;
  assign out_valid = sel ? ov1 : ov0;
  assign busy = sel ? bz1 : bz0;
  assign plain_text = sel ? pt1 : pt0;

  aes_decrypt_param_core #(.KEY_BITS(128)) dut128 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid && !sel), .in_ready(ir0),
    .cipher_text(cipher_text), .last_key(last_key[127:0]), .out_valid(ov0),
    .out_ready(out_ready), .plain_text(pt0), .busy(bz0)
  );

  aes_decrypt_param_core #(.KEY_BITS(256)) dut256 (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid && sel), .in_ready(ir1),
    .cipher_text(cipher_text), .last_key(last_key), .out_valid(ov1),
    .out_ready(out_ready), .plain_text(pt1), .busy(bz1)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  // polynomial product then reduction modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] q;
    q = '0;
    for (int i = 0; i < 8; i++) if (b[i]) q ^= 15'(a) << i;
    for (int i = 14; i >= 8; i--) if (q[i]) q ^= 15'h11b << (i - 8);
    return q[7:0];
  endfunction

  task automatic build_sbox();
    logic [7:0] v, s, c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      v = 8'h00;
      for (int y = 1; y < 256; y++) if (mul(8'(x), 8'(y)) == 8'h01) v = 8'(y);
      for (int i = 0; i < 8; i++) s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8] ^ v[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // forward FIPS-197 cipher; also returns the final round key(s) in the core's last_key layout
  task automatic encrypt(input logic [255:0] key, input int kb, input logic [127:0] pt,
                         output logic [127:0] ct, output logic [255:0] lk);
    logic [31:0] w [60];
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [31:0] tmp;
    logic [7:0] rc;
    int nk, nr;
    nk = kb / 32;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[kb-1-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      tmp = w[i-1];
      if (i % nk == 0) begin
        tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc = mul(rc, 8'h02);
      end else if (nk > 4 && i % nk == 4) tmp = subw(tmp);
      w[i] = w[i-nk] ^ tmp;
    end
    for (int n = 0; n < 16; n++) s[n] = pt[127-8*n -: 8] ^ w[n/4][31-8*(n%4) -: 8];
    for (int r = 1; r <= nr; r++) begin
      for (int n = 0; n < 16; n++) t[n] = sb[s[(n%4) + 4*(((n/4) + (n%4)) % 4)]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          s[row+4*c] = (r == nr ? t[row+4*c] :
                        mul(8'h02, t[row+4*c]) ^ mul(8'h03, t[(row+1)%4+4*c]) ^ t[(row+2)%4+4*c] ^ t[(row+3)%4+4*c])
                       ^ w[4*r+c][31-8*row -: 8];
    end
    for (int n = 0; n < 16; n++) ct[127-8*n -: 8] = s[n];
    lk = kb == 128 ? {128'h0, w[40], w[41], w[42], w[43]} : {w[52], w[53], w[54], w[55], w[56], w[57], w[58], w[59]};
  endtask

  task automatic send(input logic [127:0] ct, input logic [255:0] key);
    int n;
    n = 0;
    cipher_text = ct;
    last_key = key;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_out(input int hold);
    repeat (hold) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if ({ir0, ir1} !== 2'b00) begin fails++; $display("FAIL reset_in_ready: got %b required 00", {ir0, ir1}); end
    checks++; if ({ov0, ov1, bz0, bz1} !== 4'b0000) begin fails++; $display("FAIL reset_valid_busy: got %b required 0000", {ov0, ov1, bz0, bz1}); end
    checks++; if ({pt0, pt1} !== 256'h0) begin fails++; $display("FAIL reset_plain_text: got %h required 0", {pt0, pt1}); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if ({ir0, ir1, bz0, bz1} !== 4'b1100) begin fails++; $display("FAIL reset_release: in_ready/busy got %b required 1100", {ir0, ir1, bz0, bz1}); end
  endtask

  task automatic test_kat(input logic s);
    int lat, nr;
    sel = s;
    nr = s ? 14 : 10;
    send(s ? KAT256_CT : KAT128_CT, s ? KAT256_KEY : {128'h0, KAT128_KEY});
    wait_out(lat);
    checks++; if (lat !== nr) begin fails++; $display("FAIL kat%0d_latency: got %0d required %0d", s ? 256 : 128, lat, nr); end
    checks++; if (plain_text !== KAT_PT) begin fails++; $display("FAIL kat%0d_result: got %h required %h", s ? 256 : 128, plain_text, KAT_PT); end
    release_out(0);
    checks++; if ({in_ready, out_valid, busy} !== 3'b100) begin fails++; $display("FAIL kat%0d_idle: in_ready/out_valid/busy got %b required 100", s ? 256 : 128, {in_ready, out_valid, busy}); end
  endtask

  task automatic test_backpressure();
    int lat;
    sel = 1'b0;
    send(KAT128_CT, {128'h0, KAT128_KEY});
    wait_out(lat);
    cipher_text = rand128();
    last_key = {rand128(), rand128()};
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (plain_text !== KAT_PT || {out_valid, in_ready, busy} !== 3'b101) begin
        fails++; $display("FAIL backpressure_hold%0d: pt=%h flags=%b required pt=%h flags=101", k, plain_text, {out_valid, in_ready, busy}, KAT_PT);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if ({out_valid, in_ready, busy} !== 3'b010) begin fails++; $display("FAIL backpressure_release: out_valid/in_ready/busy got %b required 010", {out_valid, in_ready, busy}); end
    in_valid = 1'b0;
  endtask

  task automatic test_ignore();
    int lat;
    sel = 1'b0;
    send(KAT128_CT, {128'h0, KAT128_KEY});
    repeat (3) begin @(posedge clk); #1; end
    checks++; if ({in_ready, busy} !== 2'b01) begin fails++; $display("FAIL round_flags: in_ready/busy got %b required 01", {in_ready, busy}); end
    in_valid = 1'b1;
    cipher_text = rand128();
    last_key = {rand128(), rand128()};
    repeat (2) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    cipher_text = rand128();
    wait_out(lat);
    checks++; if (lat + 5 !== 10) begin fails++; $display("FAIL ignore_latency: got %0d required 10", lat + 5); end
    checks++; if (plain_text !== KAT_PT) begin fails++; $display("FAIL ignore_result: got %h required %h", plain_text, KAT_PT); end
    release_out(0);
  endtask

  task automatic test_reset_abort();
    int seen;
    sel = 1'b0;
    send(KAT128_CT, {128'h0, KAT128_KEY});
    repeat (5) begin @(posedge clk); #1; end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({ir0, ir1, ov0, ov1, bz0, bz1} !== 6'b0 || {pt0, pt1} !== 256'h0) begin
      fails++; $display("FAIL abort_outputs: flags=%b pt=%h required all zero", {ir0, ir1, ov0, ov1, bz0, bz1}, {pt0, pt1});
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) begin fails++; $display("FAIL abort_no_output: out_valid seen %0d cycles required 0", seen); end
  endtask

  task automatic test_back_to_back(input logic s);
    logic [127:0] pt [2];
    logic [127:0] ct [2];
    logic [255:0] lk [2];
    int acc_t [$];
    logic [127:0] res [$];
    logic acc;
    int nr;
    sel = s;
    nr = s ? 14 : 10;
    for (int b = 0; b < 2; b++) begin
      pt[b] = rand128();
      encrypt({rand128(), rand128()}, s ? 256 : 128, pt[b], ct[b], lk[b]);
    end
    out_ready = 1'b1;
    cipher_text = ct[0];
    last_key = lk[0];
    in_valid = 1'b1;
    for (int k = 0; k < 45; k++) begin
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        acc_t.push_back(k);
        if (acc_t.size() == 1) begin cipher_text = ct[1]; last_key = lk[1]; end
        else in_valid = 1'b0;
      end
      if (out_valid) res.push_back(plain_text);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (acc_t.size() !== 2) begin fails++; $display("FAIL b2b%0d_accepts: got %0d accepts required 2", s ? 256 : 128, acc_t.size()); end
    else if (acc_t[1] - acc_t[0] !== nr + 2) begin fails++; $display("FAIL b2b%0d_spacing: got %0d required %0d", s ? 256 : 128, acc_t[1] - acc_t[0], nr + 2); end
    checks++;
    if (res.size() !== 2) begin fails++; $display("FAIL b2b%0d_results: got %0d results required 2", s ? 256 : 128, res.size()); end
    else if (res[0] !== pt[0] || res[1] !== pt[1]) begin fails++; $display("FAIL b2b%0d_data: got %h %h required %h %h", s ? 256 : 128, res[0], res[1], pt[0], pt[1]); end
  endtask

  task automatic test_random();
    logic [127:0] pt, ct;
    logic [255:0] lk;
    int lat, nr;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      nr = s == 1 ? 14 : 10;
      for (int b = 0; b < 6; b++) begin
        pt = rand128();
        encrypt({rand128(), rand128()}, s == 1 ? 256 : 128, pt, ct, lk);
        send(ct, lk);
        wait_out(lat);
        checks++; if (lat !== nr) begin fails++; $display("FAIL random%0d_%0d_latency: got %0d required %0d", s, b, lat, nr); end
        checks++; if (plain_text !== pt) begin fails++; $display("FAIL random%0d_%0d_result: got %h required %h", s, b, plain_text, pt); end
        release_out($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_kat(1'b0);
    test_kat(1'b1);
    test_backpressure();
    test_ignore();
    test_reset_abort();
    test_kat(1'b0);
    test_back_to_back(1'b0);
    test_back_to_back(1'b1);
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
